// File: rtl/barrel_shift_pipe_if.sv
// Valid/ready stream bundle for barrel_shift_pipe.
// The out_ovf signal exists only when BARREL_SHIFT_PIPE_OVF_EN is defined.
interface barrel_shift_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int SW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_shift;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef BARREL_SHIFT_PIPE_OVF_EN
    logic             out_ovf;
`endif

    modport master (
`ifdef BARREL_SHIFT_PIPE_OVF_EN
        input  out_ovf,
`endif
        output in_valid, in_data, in_shift, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
`ifdef BARREL_SHIFT_PIPE_OVF_EN
        output out_ovf,
`endif
        input  in_valid, in_data, in_shift, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/barrel_shift_pipe.sv
// Pipelined multi-mode barrel shifter (LSL, LSR, ASR, ROL) with valid/ready back-pressure.
// Optional sticky shifted-out flag out_ovf is enabled by defining BARREL_SHIFT_PIPE_OVF_EN.
module barrel_shift_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic                clk,
    input logic                rst,
    barrel_shift_pipe_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    logic stall;
    logic en;

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       mode,
                                                    input logic             sign,
                                                    input int               amt);
        logic [WIDTH-1:0] r;
        case (mode)
            2'b00:   r = d << amt;
            2'b01:   r = d >> amt;
            2'b10:   r = (d >> amt) | ({WIDTH{sign}} << (WIDTH - amt));
            default: r = (d << amt) | (d >> (WIDTH - amt));
        endcase
        return r;
    endfunction

`ifdef BARREL_SHIFT_PIPE_OVF_EN
    function automatic logic lost_bits(input logic [WIDTH-1:0] d,
                                       input logic [1:0]       mode,
                                       input logic             sign,
                                       input int               amt);
        logic [WIDTH-1:0] low_mask;
        logic             r;
        low_mask = ~({WIDTH{1'b1}} << amt);
        case (mode)
            2'b00:   r = (d >> (WIDTH - amt)) != '0;
            2'b01:   r = (d & low_mask) != '0;
            2'b10:   r = ((d ^ {WIDTH{sign}}) & low_mask) != '0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    for (genvar k = 0; k < STAGES; k++) begin : stg
        logic             src_v;
        logic [WIDTH-1:0] src_d;
        logic [SW-1:0]    src_s;
        logic [1:0]       src_m;
        logic             src_sign;
        logic [WIDTH-1:0] nxt_d;
        logic             v_q;
        logic [WIDTH-1:0] d_q;
`ifdef BARREL_SHIFT_PIPE_OVF_EN
        logic             src_ovf;
        logic             nxt_ovf;
        logic             ovf_q;
`endif

        if (k == 0) begin : g_src
            assign src_v    = bus.in_valid && bus.in_ready;
            assign src_d    = bus.in_data;
            assign src_s    = bus.in_shift;
            assign src_m    = bus.in_mode;
            assign src_sign = bus.in_data[WIDTH-1];
`ifdef BARREL_SHIFT_PIPE_OVF_EN
            assign src_ovf  = 1'b0;
`endif
        end else begin : g_src
            assign src_v    = stg[k-1].v_q;
            assign src_d    = stg[k-1].d_q;
            assign src_s    = stg[k-1].g_ctl.s_q;
            assign src_m    = stg[k-1].g_ctl.m_q;
            assign src_sign = stg[k-1].g_ctl.sign_q;
`ifdef BARREL_SHIFT_PIPE_OVF_EN
            assign src_ovf  = stg[k-1].ovf_q;
`endif
        end

        // Apply the power-of-two sub-shifts assigned to this stage, in ascending order.
        always_comb begin
            nxt_d = src_d;
`ifdef BARREL_SHIFT_PIPE_OVF_EN
            nxt_ovf = src_ovf;
`endif
            for (int i = 0; i < SW; i++) begin
                if (((i * STAGES) / SW == k) && src_s[i]) begin
`ifdef BARREL_SHIFT_PIPE_OVF_EN
                    nxt_ovf = nxt_ovf | lost_bits(nxt_d, src_m, src_sign, 1 << i);
`endif
                    nxt_d = shift_once(nxt_d, src_m, src_sign, 1 << i);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (en) begin
                v_q <= src_v;
                d_q <= nxt_d;
            end
        end

`ifdef BARREL_SHIFT_PIPE_OVF_EN
        always_ff @(posedge clk) begin
            if (rst) begin
                ovf_q <= 1'b0;
            end else if (en) begin
                ovf_q <= nxt_ovf;
            end
        end
`endif

        // The final stage only needs the result; control travels to later stages only.
        if (k < STAGES - 1) begin : g_ctl
            logic [SW-1:0] s_q;
            logic [1:0]    m_q;
            logic          sign_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s_q    <= '0;
                    m_q    <= 2'b00;
                    sign_q <= 1'b0;
                end else if (en) begin
                    s_q    <= src_s;
                    m_q    <= src_m;
                    sign_q <= src_sign;
                end
            end
        end
    end

    assign stall         = stg[STAGES-1].v_q && !bus.out_ready;
    assign en            = !stall;
    assign bus.in_ready  = !stall && !rst;
    assign bus.out_valid = stg[STAGES-1].v_q;
    assign bus.out_data  = stg[STAGES-1].d_q;
`ifdef BARREL_SHIFT_PIPE_OVF_EN
    assign bus.out_ovf   = stg[STAGES-1].ovf_q;
`endif
endmodule
